// File: rtl/br_tag_ctrl_if.sv
// Bus between dispatch / branch resolver (master) and the branch tag
// controller (slave). Only clock and reset stay outside as plain ports.
//
// Request/grant rule: dis_br_1/dis_br_2 are requests that dispatch holds
// until granted. A request is accepted in exactly the cycle its
// br_wr_en_x is high; that cycle also carries br_marker_in_x. A slot-2
// request that is not granted sees dis_hold_2=1. A slot-1 request is
// throttled by dispatch from br_stall. ex_br_done is a one-cycle event
// that needs no grant.
interface br_tag_ctrl_if #(
    parameter int NUM_TAGS = 4,
    parameter int TAG_W    = 3
) ();
    logic                dis_br_1;
    logic                dis_br_2;
    logic                ex_br_done;
    logic [TAG_W-1:0]    ex_br_marker;
    logic                ex_br_mispredict;
    logic                br_wr_en_1;
    logic                br_wr_en_2;
    logic [TAG_W-1:0]    br_marker_in_1;
    logic [TAG_W-1:0]    br_marker_in_2;
    logic                dis_hold_2;
    logic [1:0]          br_stall;
    logic                br_mispredict;
    logic [TAG_W-1:0]    br_mispre_marker;
    logic [NUM_TAGS-1:0] br_kill_mask;
    logic                state_dbg;     // 1 while the controller is in RECOVER

    modport master (
        output dis_br_1, dis_br_2, ex_br_done, ex_br_marker, ex_br_mispredict,
        input  br_wr_en_1, br_wr_en_2, br_marker_in_1, br_marker_in_2,
               dis_hold_2, br_stall, br_mispredict, br_mispre_marker,
               br_kill_mask, state_dbg
    );

    modport slave (
        input  dis_br_1, dis_br_2, ex_br_done, ex_br_marker, ex_br_mispredict,
        output br_wr_en_1, br_wr_en_2, br_marker_in_1, br_marker_in_2,
               dis_hold_2, br_stall, br_mispredict, br_mispre_marker,
               br_kill_mask, state_dbg
    );
endinterface

// File: rtl/br_tag_ctrl.sv
// Branch tag controller: allocates checkpoint markers (one per cycle),
// retires them on correct resolve, and turns a mispredict into a one-cycle
// recovery pulse carrying the kill mask of the branch and all younger ones.
module br_tag_ctrl #(
    parameter int NUM_TAGS = 4,
    parameter int TAG_W    = 3
) (
    input  logic         clock,
    input  logic         reset,
    br_tag_ctrl_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_TAGS);

    typedef enum logic {RUN = 1'b0, RECOVER = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [NUM_TAGS-1:0] valid_q, valid_d;
    logic [NUM_TAGS-1:0] gen_q, gen_d;
    // younger_q[j][s] = 1 : slot s was allocated after slot j
    logic [NUM_TAGS-1:0] younger_q [NUM_TAGS];
    logic [NUM_TAGS-1:0] younger_d [NUM_TAGS];
    logic [1:0]          stall_q, stall_d;
    logic                misp_q;
    logic [TAG_W-1:0]    mmk_q;
    logic [NUM_TAGS-1:0] kill_q;

    logic [IDX_W-1:0]    res_idx;
    logic                res_valid, mis_valid, cor_valid;
    logic [NUM_TAGS-1:0] kill_vec;
    logic                has_free;
    logic [IDX_W-1:0]    free_idx;
    logic                alloc_ok, grant_1, grant_2;
    logic [TAG_W-1:0]    grant_marker;
    logic [IDX_W:0]      free_cnt;

    // Resolve qualification, kill set and lowest-free-slot search.
    always_comb begin
        res_idx   = bus.ex_br_marker[IDX_W-1:0];
        res_valid = bus.ex_br_done & valid_q[res_idx]
                    & (gen_q[res_idx] == bus.ex_br_marker[TAG_W-1]);
        mis_valid = res_valid & bus.ex_br_mispredict;
        cor_valid = res_valid & ~bus.ex_br_mispredict;
        kill_vec  = younger_q[res_idx] | (NUM_TAGS'(1) << res_idx);
        has_free  = 1'b0;
        free_idx  = '0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                has_free = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
        // A mispredict in the same cycle wins so no squashed branch is checkpointed.
        alloc_ok     = (state_q == RUN) & ~mis_valid & has_free;
        grant_1      = alloc_ok & bus.dis_br_1;
        grant_2      = alloc_ok & ~bus.dis_br_1 & bus.dis_br_2;
        grant_marker = {~gen_q[free_idx], free_idx};
    end

    assign bus.br_wr_en_1       = grant_1;
    assign bus.br_wr_en_2       = grant_2;
    assign bus.br_marker_in_1   = grant_1 ? grant_marker : '0;
    assign bus.br_marker_in_2   = grant_2 ? grant_marker : '0;
    assign bus.dis_hold_2       = bus.dis_br_2 & ~grant_2;
    assign bus.br_stall         = stall_q;
    assign bus.br_mispredict    = misp_q;
    assign bus.br_mispre_marker = mmk_q;
    assign bus.br_kill_mask     = kill_q;
    assign bus.state_dbg        = (state_q == RECOVER);

    // Next-state: FSM, slot table updates (resolve, kill, then allocate) and stall.
    always_comb begin
        state_d   = mis_valid ? RECOVER : RUN;
        valid_d   = valid_q;
        gen_d     = gen_q;
        younger_d = younger_q;
        stall_d   = 2'b00;
        free_cnt  = '0;
        if (cor_valid) begin
            valid_d[res_idx] = 1'b0;
            for (int j = 0; j < NUM_TAGS; j++) younger_d[j][res_idx] = 1'b0;
        end
        if (mis_valid) begin
            valid_d = valid_d & ~kill_vec;
            for (int j = 0; j < NUM_TAGS; j++) begin
                if (kill_vec[j]) younger_d[j] = '0;
                younger_d[j] = younger_d[j] & ~kill_vec;
            end
        end
        // Column uses post-resolve validity; the free slot's own bit is 0 here.
        if (grant_1 | grant_2) begin
            for (int j = 0; j < NUM_TAGS; j++) younger_d[j][free_idx] = valid_d[j];
            younger_d[free_idx] = '0;
            valid_d[free_idx]   = 1'b1;
            gen_d[free_idx]     = ~gen_q[free_idx];
        end
        for (int i = 0; i < NUM_TAGS; i++) begin
            if (!valid_d[i]) free_cnt = free_cnt + (IDX_W+1)'(1);
        end
        if (state_d == RECOVER || free_cnt == '0) stall_d = 2'b11;
        else if (free_cnt == (IDX_W+1)'(1))       stall_d = 2'b01;
        else                                      stall_d = 2'b00;
    end

    // State register and registered recovery outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            valid_q <= '0;
            gen_q   <= '0;
            for (int j = 0; j < NUM_TAGS; j++) younger_q[j] <= '0;
            stall_q <= 2'b00;
            misp_q  <= 1'b0;
            mmk_q   <= '0;
            kill_q  <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            gen_q   <= gen_d;
            for (int j = 0; j < NUM_TAGS; j++) younger_q[j] <= younger_d[j];
            stall_q <= stall_d;
            misp_q  <= mis_valid;
            mmk_q   <= mis_valid ? bus.ex_br_marker : '0;
            kill_q  <= mis_valid ? kill_vec : '0;
        end
    end
endmodule

// File: tb/tb_br_tag_ctrl.sv
// Bench for br_tag_ctrl: vector table with a scoreboard for the registered
// outputs, plus a hand sequence for reset in the middle of a recovery pulse.
module tb_br_tag_ctrl;
    logic clock = 1'b0;
    logic reset = 1'b0;

    // Clock: 10 time-unit period.
    always #5 clock = ~clock;

    br_tag_ctrl_if bus ();

    br_tag_ctrl dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic       rst;
        logic       d1, d2, done;
        logic [2:0] mk;
        logic       mis;
        logic       wr1, wr2;
        logic [2:0] m1, m2;
        logic       h2;
        logic [1:0] stall;
        logic       misp;
        logic [2:0] mmk;
        logic [3:0] kill;
    } vec_t;

    vec_t       tbl[$];
    logic [9:0] exp_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;

    function automatic vec_t mk_vec(int rst, int d1, int d2, int done, int mk, int mis,
                                    int wr1, int wr2, int m1, int m2, int h2,
                                    int stall, int misp, int mmk, int kill);
        vec_t v;
        v.rst = 1'(rst);   v.d1 = 1'(d1);   v.d2 = 1'(d2);   v.done = 1'(done);
        v.mk = 3'(mk);     v.mis = 1'(mis); v.wr1 = 1'(wr1); v.wr2 = 1'(wr2);
        v.m1 = 3'(m1);     v.m2 = 3'(m2);   v.h2 = 1'(h2);   v.stall = 2'(stall);
        v.misp = 1'(misp); v.mmk = 3'(mmk); v.kill = 4'(kill);
        return v;
    endfunction

    function automatic void add(int rst, int d1, int d2, int done, int mk, int mis,
                                int wr1, int wr2, int m1, int m2, int h2,
                                int stall, int misp, int mmk, int kill);
        tbl.push_back(mk_vec(rst, d1, d2, done, mk, mis, wr1, wr2, m1, m2, h2,
                             stall, misp, mmk, kill));
    endfunction

    task automatic check(string name, logic [15:0] act, logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        bus.dis_br_1 = 1'b0;  bus.dis_br_2 = 1'b0;  bus.ex_br_done = 1'b0;
        bus.ex_br_marker = 3'd0;  bus.ex_br_mispredict = 1'b0;
    endtask

    function automatic logic [8:0] comb_now();
        return {bus.br_wr_en_1, bus.br_wr_en_2, bus.br_marker_in_1,
                bus.br_marker_in_2, bus.dis_hold_2};
    endfunction

    function automatic logic [9:0] reg_now();
        return {bus.br_stall, bus.br_mispredict, bus.br_mispre_marker, bus.br_kill_mask};
    endfunction

    task automatic do_reset(string tag);
        drive_idle();
        repeat ($urandom_range(0, 2)) @(posedge clock);
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check({tag, " reset regs"}, 16'(reg_now()), 16'd0);
        check({tag, " reset comb"}, 16'(comb_now()), 16'd0);
        check({tag, " reset state"}, 16'(bus.state_dbg), 16'd0);
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic run_vec(vec_t v, string tag);
        logic [9:0] exp_r;
        if (v.rst) do_reset(tag);
        @(negedge clock);
        bus.dis_br_1 = v.d1;  bus.dis_br_2 = v.d2;  bus.ex_br_done = v.done;
        bus.ex_br_marker = v.mk;  bus.ex_br_mispredict = v.mis;
        #1;
        check({tag, " grant"}, 16'(comb_now()), 16'({v.wr1, v.wr2, v.m1, v.m2, v.h2}));
        exp_q.push_back({v.stall, v.misp, v.mmk, v.kill});
        @(posedge clock);
        #1;
        exp_r = exp_q.pop_front();
        check({tag, " stall/misp/marker/kill"}, 16'(reg_now()), 16'(exp_r));
    endtask

    initial begin
        drive_idle();
        //  rst d1 d2 dn mk ms | wr1 wr2 m1 m2 h2 | stall misp mmk kill
        // fill from empty, full, correct resolve + alloc, wrap, stale, kill
        add(1, 1,0,0,0,0,  1,0,4,0,0,  0,0,0,4'b0000);
        add(0, 1,0,0,0,0,  1,0,5,0,0,  0,0,0,4'b0000);
        add(0, 1,0,0,0,0,  1,0,6,0,0,  1,0,0,4'b0000);
        add(0, 1,0,0,0,0,  1,0,7,0,0,  3,0,0,4'b0000);
        add(0, 1,0,0,0,0,  0,0,0,0,0,  3,0,0,4'b0000);
        add(0, 0,1,0,0,0,  0,0,0,0,1,  3,0,0,4'b0000);
        add(0, 1,0,1,4,0,  0,0,0,0,0,  1,0,0,4'b0000);
        add(0, 1,0,0,0,0,  1,0,0,0,0,  3,0,0,4'b0000);
        add(0, 0,0,1,4,1,  0,0,0,0,0,  3,0,0,4'b0000);
        add(0, 1,0,1,7,1,  0,0,0,0,0,  3,1,7,4'b1001);
        add(0, 1,0,0,0,0,  0,0,0,0,0,  0,0,0,4'b0000);
        add(0, 1,0,0,0,0,  1,0,4,0,0,  1,0,0,4'b0000);
        // dual branch
        add(1, 1,1,0,0,0,  1,0,4,0,1,  0,0,0,4'b0000);
        add(0, 0,1,0,0,0,  0,1,0,5,0,  0,0,0,4'b0000);
        // mispredict kills younger, then stale resolves
        add(1, 1,0,0,0,0,  1,0,4,0,0,  0,0,0,4'b0000);
        add(0, 1,0,0,0,0,  1,0,5,0,0,  0,0,0,4'b0000);
        add(0, 1,0,0,0,0,  1,0,6,0,0,  1,0,0,4'b0000);
        add(0, 0,0,1,5,1,  0,0,0,0,0,  3,1,5,4'b0110);
        add(0, 0,0,0,0,0,  0,0,0,0,0,  0,0,0,4'b0000);
        add(0, 0,0,1,6,0,  0,0,0,0,0,  0,0,0,4'b0000);
        add(0, 1,0,0,0,0,  1,0,1,0,0,  0,0,0,4'b0000);
        add(0, 0,0,1,6,1,  0,0,0,0,0,  0,0,0,4'b0000);
        add(0, 1,0,0,0,0,  1,0,2,0,0,  1,0,0,4'b0000);
        // mispredict vs allocation, back-to-back mispredicts
        add(1, 1,0,0,0,0,  1,0,4,0,0,  0,0,0,4'b0000);
        add(0, 1,0,0,0,0,  1,0,5,0,0,  0,0,0,4'b0000);
        add(0, 1,0,1,4,1,  0,0,0,0,0,  3,1,4,4'b0011);
        add(0, 1,0,0,0,0,  0,0,0,0,0,  0,0,0,4'b0000);
        add(0, 1,0,0,0,0,  1,0,0,0,0,  0,0,0,4'b0000);
        add(0, 1,0,0,0,0,  1,0,1,0,0,  0,0,0,4'b0000);
        add(0, 0,0,1,1,1,  0,0,0,0,0,  3,1,1,4'b0010);
        add(0, 0,0,1,0,1,  0,0,0,0,0,  3,1,0,4'b0001);
        add(0, 0,0,0,0,0,  0,0,0,0,0,  0,0,0,4'b0000);
        // lead-in for reset during recovery
        add(1, 1,0,0,0,0,  1,0,4,0,0,  0,0,0,4'b0000);
        add(0, 1,0,0,0,0,  1,0,5,0,0,  0,0,0,4'b0000);
        add(0, 1,0,0,0,0,  1,0,6,0,0,  1,0,0,4'b0000);
        add(0, 0,0,1,5,1,  0,0,0,0,0,  3,1,5,4'b0110);

        foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));

        // Reset asserted mid-cycle while the recovery pulse is high.
        drive_idle();
        #2;
        reset = 1'b0;
        #1;
        check("midrec regs", 16'(reg_now()), 16'd0);
        check("midrec state", 16'(bus.state_dbg), 16'd0);
        check("midrec comb", 16'(comb_now()), 16'd0);
        @(negedge clock);
        reset = 1'b1;
        // All four slots must be free again, with gen bits cleared.
        run_vec(mk_vec(0, 1,0,0,0,0, 1,0,4,0,0, 0,0,0,0), "post0");
        run_vec(mk_vec(0, 1,0,0,0,0, 1,0,5,0,0, 0,0,0,0), "post1");
        run_vec(mk_vec(0, 1,0,0,0,0, 1,0,6,0,0, 1,0,0,0), "post2");
        run_vec(mk_vec(0, 1,0,0,0,0, 1,0,7,0,0, 3,0,0,0), "post3");

        check("scoreboard drained", 16'(exp_q.size()), 16'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
